// File: rtl/fib_seq_ctrl_if.sv
// rtl/fib_seq_ctrl_if.sv - start/done handshake and datapath control bundle
interface fib_seq_ctrl_if #(
  parameter int N_W = 5
);
  logic           start;
  logic [N_W-1:0] n;
  logic           ovf;
  logic           clr_dp;
  logic           step_en;
  logic           busy;
  logic           done;
  logic           err;
  logic           err_flag;
  logic [N_W-1:0] cnt;

  modport master (
    output start, n, ovf,
    input  clr_dp, step_en, busy, done, err, err_flag, cnt
  );

  modport slave (
    input  start, n, ovf,
    output clr_dp, step_en, busy, done, err, err_flag, cnt
  );
endinterface

// File: rtl/fib_seq_ctrl.sv
// rtl/fib_seq_ctrl.sv - Fibonacci datapath sequencer
// Clears a/b, then issues n step enables; aborts early when the adder carry flags an unfit term.
module fib_seq_ctrl #(
  parameter int N_W = 5
) (
  input  logic           clk,
  input  logic           CLR,
  fib_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_STEP = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N_W-1:0] r_n_lat;
  logic [N_W-1:0] r_cnt;
  logic           r_err_flag;
  logic           w_last;
  logic           w_abort;

  // Widened compare keeps cnt+1 from aliasing to 0 when n_lat is all ones.
  assign w_last  = ({1'b0, r_cnt} + {{N_W{1'b0}}, 1'b1}) == {1'b0, r_n_lat};
  assign w_abort = bus.ovf && !w_last;

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_INIT;
      S_INIT: w_next = (r_n_lat == '0) ? S_DONE : S_STEP;
      S_STEP: begin
        if (w_abort)     w_next = S_ERR;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      r_n_lat    <= '0;
      r_cnt      <= '0;
      r_err_flag <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_n_lat    <= bus.n;
            r_cnt      <= '0;
            r_err_flag <= 1'b0;
          end
        end
        S_STEP: begin
          if (w_abort) r_err_flag <= 1'b1;
          else         r_cnt      <= r_cnt + {{(N_W-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.clr_dp   = 1'b0;
    bus.step_en  = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.err      = 1'b0;
    bus.err_flag = r_err_flag;
    bus.cnt      = r_cnt;
    case (r_state)
      S_INIT: begin
        bus.clr_dp = 1'b1;
        bus.busy   = 1'b1;
      end
      S_STEP: begin
        bus.step_en = !w_abort;
        bus.busy    = 1'b1;
      end
      S_DONE: begin
        bus.done = 1'b1;
        bus.busy = 1'b1;
      end
      S_ERR: begin
        bus.err  = 1'b1;
        bus.busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/fib_seq_ctrl.md
Name: fib_seq_ctrl

Overview:
- Control FSM for the Fibonacci datapath, which is two registers a/b built from clear-capable mux-flop cells plus an adder.
- Accepts a term index n through a start/done handshake.
- Sequences datapath clear and step enables until a holds F(n).
- Aborts with an error if the adder carry shows that an intermediate term will not fit the datapath width.

Parameters:
N_W, 5, width of term index n (max n = 2^N_W - 1)

Ports:
clk  input  1  system clock, rising edge
CLR  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
n  input  N_W  term index; captured on accepted start
ovf  input  1  combinational carry-out of datapath adder a+b
clr_dp  output  1  datapath init: a<=0, b<=1 on next edge
step_en  output  1  datapath step: a<=b, b<=a+b on next edge
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse, a holds F(n)
err  output  1  one-cycle pulse on overflow abort
err_flag  output  1  sticky overflow flag; cleared by next accepted start
cnt  output  N_W  steps completed in current run (debug/observe)

Behaviour:
- Reset: CLR=1 asynchronously forces state=IDLE.
  - All outputs go to 0: clr_dp, step_en, busy, done, err, err_flag, cnt.
  - Internal n_lat is also cleared to 0.
  - Reset mid-run abandons the run; no done or err is produced.
- States: IDLE, INIT, STEP, DONE, ERR. Outputs are decoded from state and registers (Moore), except step_en, which also depends on ovf.
- IDLE:
  - start=1 → latch n into n_lat, cnt<=0, err_flag<=0, go to INIT.
  - start=0 → stay in IDLE.
- INIT (exactly 1 cycle):
  - clr_dp=1, busy=1.
  - n_lat==0 → DONE; otherwise → STEP.
- STEP, one cycle per step:
  - busy=1.
  - last = (cnt+1 == n_lat).
  - Normal case: step_en=1, cnt<=cnt+1. last → DONE; else stay in STEP.
  - Overflow: ovf=1 and !last → step_en=0, cnt unchanged, err_flag<=1, go to ERR.
  - ovf=1 and last → ignored. New b is discarded and a receives a valid value. Step proceeds normally to DONE.
- DONE (1 cycle): done=1, busy=1, then → IDLE.
- ERR (1 cycle): err=1, busy=1, then → IDLE. err_flag stays 1 until the next accepted start.
- Latency from start sampled at edge k:
  - INIT occupies cycle k+1.
  - STEP occupies cycles k+2 .. k+n+1.
  - done is high in cycle k+n+2 (k+2 for n=0).
- start while busy=1 is ignored, not queued.
- start held high through DONE: re-sampled in IDLE, so back-to-back runs have one IDLE cycle between them.
- n changes after capture have no effect on the run in progress.
- cnt never wraps: maximum value is n_lat ≤ 2^N_W-1.
- clr_dp and step_en are never high in the same cycle.

Test Plan:
1. Reset, n=0 → no spurious outputs on reset. Hold CLR=1 for 3 cycles with start=1: all outputs 0 and state stays IDLE. Release reset, start with n=0: clr_dp pulses one cycle, done 2 cycles after start, step_en never high.
2. Basic run, n=10 → clr_dp high 1 cycle, then step_en high for exactly 10 consecutive cycles. cnt goes 1..10, then done pulses. Datapath model a=55.
3. Overflow boundary, 16-bit datapath model:
   - n=24: ovf rises on step 24 (last), so it is ignored. done pulses, a=46368, err_flag=0.
   - n=25: ovf on step 24 (not last) → step_en low that cycle, err pulses, err_flag=1, cnt=23, no done.
4. Sticky flag, ignored start → after the n=25 error, err_flag stays 1 across IDLE. A new start with n=5 clears it on acceptance, and done follows with a=5. A start pulse issued mid-run has no effect on cnt or timing.
5. Reset mid-run → assert CLR asynchronously (between edges) during STEP with cnt=4 of n=20. Outputs drop to 0 immediately, with no done or err. After release, start with n=3 completes normally with a=2.
6. Back-to-back → hold start=1 continuously with n=7: runs repeat with done every 10 cycles (1 IDLE + 1 INIT + 7 STEP + 1 DONE). busy is low only in the single IDLE cycle.
